// File: rtl/coherence_bus_arbiter_if.sv
// Shared coherence bus handshake between the per-core caches and the arbiter.
//   cache_req   - per-cache level request (cache side drives)
//   bus_done    - one-cycle completion pulse from memory/snoop side
//   grant       - one-hot (or zero) grant (arbiter drives)
//   grant_id    - index of the granted cache, bus mux select
//   bus_busy    - high whenever a grant is held
//   timeout_err - one-cycle pulse when the watchdog forces a release
// Modports: master = cache/memory side, slave = arbiter side.
interface coherence_bus_arbiter_if #(
  parameter int NUM_CACHES = 4
);
  localparam int ID_W = $clog2(NUM_CACHES);

  logic [NUM_CACHES-1:0] cache_req;
  logic                  bus_done;
  logic [NUM_CACHES-1:0] grant;
  logic [ID_W-1:0]       grant_id;
  logic                  bus_busy;
  logic                  timeout_err;

  modport master (
    output cache_req, bus_done,
    input  grant, grant_id, bus_busy, timeout_err
  );

  modport slave (
    input  cache_req, bus_done,
    output grant, grant_id, bus_busy, timeout_err
  );
endinterface

// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter for the shared MESI coherence bus. Grants one cache at a
// time, holds the grant until bus_done, an abandoned request, or the watchdog
// expires, then inserts a one-cycle zero-grant turnaround before re-arbitrating.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - coherence_bus_arbiter_if.slave (cache_req/bus_done in,
//          grant/grant_id/bus_busy/timeout_err out, all outputs registered)
module coherence_bus_arbiter #(
  parameter int NUM_CACHES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  coherence_bus_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_CACHES);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    TURN    = 2'd2
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [NUM_CACHES-1:0] grant_q;
  logic [ID_W-1:0]       grant_id_q;
  logic                  bus_busy_q;
  logic                  timeout_err_q;
  logic [WD_W-1:0]       wd_cnt;

  logic                  win_valid;
  logic [ID_W-1:0]       win_idx;
  logic [ID_W-1:0]       ptr_next;
  logic                  owner_req;
  logic                  wd_expire;

  // First requester at or after ptr, wrapping modulo NUM_CACHES.
  always_comb begin
    int c;
    win_valid = 1'b0;
    win_idx   = '0;
    c         = 0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      c = (int'(ptr) + i) % NUM_CACHES;
      if (!win_valid && bus.cache_req[c]) begin
        win_valid = 1'b1;
        win_idx   = ID_W'(c);
      end
    end
  end

  assign ptr_next = (win_idx == ID_W'(NUM_CACHES - 1)) ? '0 : win_idx + 1'b1;

  // grant is one-hot, so overlap with cache_req is the owner's own request.
  assign owner_req = |(bus.cache_req & grant_q);

  // Counter is cleared on the granting edge, so holding it at T-1 now means
  // this edge completes T cycles of ownership.
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      wd_cnt        <= '0;
    end else begin
      timeout_err_q <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (win_valid) begin
            state      <= GRANTED;
            grant_q    <= NUM_CACHES'(1) << win_idx;
            grant_id_q <= win_idx;
            bus_busy_q <= 1'b1;
            ptr        <= ptr_next;
            wd_cnt     <= '0;
          end else begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            bus_busy_q <= 1'b0;
          end
        end
        GRANTED: begin
          if (bus.bus_done || !owner_req || wd_expire) begin
            state         <= TURN;
            grant_q       <= '0;
            grant_id_q    <= '0;
            bus_busy_q    <= 1'b0;
            timeout_err_q <= !bus.bus_done && owner_req;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
          bus_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.bus_busy    = bus_busy_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Testbench for coherence_bus_arbiter (NUM_CACHES=4, TIMEOUT_CYCLES=8).
// Directed request/done sequences; a bench-side ownership model is compared
// against the DUT outputs every cycle, and literal expectations pin the model.
module tb_coherence_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk;
  logic rst;

  coherence_bus_arbiter_if #(.NUM_CACHES(N)) bus ();

  coherence_bus_arbiter #(
    .NUM_CACHES    (N),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the bus (-1 = nobody), the rotating start index, and how
  // many edges the current owner has been holding the bus.
  int m_owner     = -1;
  int m_ptr       = 0;
  int m_held      = 0;
  bit m_terr      = 1'b0;
  bit model_valid = 1'b0;

  function automatic logic [N-1:0] owner_to_grant(input int o);
    logic [N-1:0] one;
    one = 1;
    return (o < 0) ? '0 : (one << o);
  endfunction

  always @(posedge clk) begin
    int nxt_owner;
    int nxt_ptr;
    int nxt_held;
    bit nxt_terr;
    int c;
    nxt_owner = m_owner;
    nxt_ptr   = m_ptr;
    nxt_held  = m_held;
    nxt_terr  = 1'b0;
    c         = 0;
    if (rst) begin
      nxt_owner = -1;
      nxt_ptr   = 0;
      nxt_held  = 0;
    end else if (m_owner >= 0) begin
      nxt_held = m_held + 1;
      if (bus.bus_done) begin
        nxt_owner = -1;
      end else if (!bus.cache_req[m_owner]) begin
        nxt_owner = -1;
      end else if (nxt_held >= TO) begin
        nxt_owner = -1;
        nxt_terr  = 1'b1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (nxt_owner < 0 && bus.cache_req[c]) begin
          nxt_owner = c;
          nxt_ptr   = (c + 1) % N;
          nxt_held  = 0;
        end
      end
    end
    m_owner     <= nxt_owner;
    m_ptr       <= nxt_ptr;
    m_held      <= nxt_held;
    m_terr      <= nxt_terr;
    model_valid <= 1'b1;
  end

  // Per-cycle comparison of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      n_vectors = n_vectors + 4;
      if (bus.grant !== owner_to_grant(m_owner)) begin
        n_miscompares++;
        $display("[TB] FAIL model_grant t=%0t: got %b expected %b", $time, bus.grant, owner_to_grant(m_owner));
      end
      if (bus.grant_id !== ((m_owner < 0) ? 2'd0 : 2'(m_owner))) begin
        n_miscompares++;
        $display("[TB] FAIL model_grant_id t=%0t: got %0d expected %0d", $time, bus.grant_id, (m_owner < 0) ? 0 : m_owner);
      end
      if (bus.bus_busy !== (m_owner >= 0)) begin
        n_miscompares++;
        $display("[TB] FAIL model_bus_busy t=%0t: got %b expected %b", $time, bus.bus_busy, m_owner >= 0);
      end
      if (bus.timeout_err !== m_terr) begin
        n_miscompares++;
        $display("[TB] FAIL model_timeout_err t=%0t: got %b expected %b", $time, bus.timeout_err, m_terr);
      end
    end
  end

  // Drive one cycle of inputs, then land on the following falling edge.
  task automatic apply_stimulus(input logic r, input logic [N-1:0] req, input logic done);
    rst           = r;
    bus.cache_req = req;
    bus.bus_done  = done;
    @(negedge clk);
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic check_output(input string name, input logic [N-1:0] exp_grant,
                              input int exp_id, input logic exp_terr);
    n_vectors = n_vectors + 4;
    if (bus.grant !== exp_grant || bus.grant_id !== 2'(exp_id) ||
        bus.bus_busy !== (exp_grant != '0) || bus.timeout_err !== exp_terr) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got grant=%b id=%0d busy=%b terr=%b expected grant=%b id=%0d busy=%b terr=%b",
               name, bus.grant, bus.grant_id, bus.bus_busy, bus.timeout_err,
               exp_grant, exp_id, exp_grant != '0, exp_terr);
    end
    if (owner_to_grant(m_owner) !== exp_grant || m_terr !== exp_terr) begin
      n_miscompares++;
      $display("[TB] FAIL %s_model: got owner=%0d terr=%b expected grant=%b terr=%b",
               name, m_owner, m_terr, exp_grant, exp_terr);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cache_req = 4'b1111;
    bus.bus_done  = 1'b0;
    @(negedge clk);

    // Reset holds everything at zero even with all requests up.
    apply_stimulus(1'b1, 4'b1111, 1'b0);
    apply_stimulus(1'b1, 4'b1111, 1'b0);
    check_output("reset", 4'b0000, 0, 1'b0);

    // Single request, release, idle.
    apply_stimulus(1'b0, 4'b0100, 1'b0);
    check_output("single_grant", 4'b0100, 2, 1'b0);
    apply_stimulus(1'b0, 4'b0100, 1'b1);
    check_output("single_release", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("single_idle", 4'b0000, 0, 1'b0);

    // bus_done while idle is ignored.
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("done_in_idle", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);

    // Round robin from ptr=0 with all requesting: 0,1,2,3,0.
    apply_stimulus(1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 4'b1111, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check_output("rr_grant", owner_to_grant(k % N), k % N, 1'b0);
      apply_stimulus(1'b0, 4'b1111, 1'b0);
      apply_stimulus(1'b0, 4'b1111, 1'b0);
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      check_output("rr_gap", 4'b0000, 0, 1'b0);
      apply_stimulus(1'b0, 4'b1111, 1'b0);
    end
    check_output("rr_after", 4'b0010, 1, 1'b0);

    // Grant cache 3, then wrap to 0 and skip to 2.
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b1000, 1'b0);
    check_output("wrap_grant3", 4'b1000, 3, 1'b0);
    apply_stimulus(1'b0, 4'b0101, 1'b1);
    check_output("wrap_release", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0101, 1'b0);
    check_output("wrap_grant0", 4'b0001, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0101, 1'b1);
    apply_stimulus(1'b0, 4'b0101, 1'b0);
    check_output("skip_grant2", 4'b0100, 2, 1'b0);

    // Abandon: owner 2 drops its request after 2 cycles.
    apply_stimulus(1'b0, 4'b0101, 1'b0);
    check_output("abandon_hold", 4'b0100, 2, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 1'b0);
    check_output("abandon_release", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0001, 1'b0);
    check_output("abandon_next", 4'b0001, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b0);

    // bus_done together with owner request drop: one clean release.
    apply_stimulus(1'b0, 4'b0010, 1'b0);
    check_output("simul_grant", 4'b0010, 1, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    check_output("simul_release", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("simul_idle", 4'b0000, 0, 1'b0);

    // Watchdog: cache 1 holds for TO cycles, others queue behind it.
    apply_stimulus(1'b0, 4'b0010, 1'b0);
    check_output("wd_grant", 4'b0010, 1, 1'b0);
    for (int j = 1; j < TO; j++) begin
      apply_stimulus(1'b0, 4'b1011, 1'b0);
      check_output("wd_hold", 4'b0010, 1, 1'b0);
    end
    apply_stimulus(1'b0, 4'b1011, 1'b0);
    check_output("wd_expire", 4'b0000, 0, 1'b1);
    apply_stimulus(1'b0, 4'b1011, 1'b0);
    check_output("wd_next3", 4'b1000, 3, 1'b0);
    apply_stimulus(1'b0, 4'b1011, 1'b1);
    apply_stimulus(1'b0, 4'b1011, 1'b0);
    check_output("wd_next0", 4'b0001, 0, 1'b0);
    apply_stimulus(1'b0, 4'b1011, 1'b1);
    apply_stimulus(1'b0, 4'b1011, 1'b0);
    check_output("wd_regrant1", 4'b0010, 1, 1'b0);

    // Reset while granted, then ptr restarts at 0.
    apply_stimulus(1'b1, 4'b1011, 1'b0);
    check_output("rst_granted", 4'b0000, 0, 1'b0);
    apply_stimulus(1'b0, 4'b1010, 1'b0);
    check_output("rst_regrant", 4'b0010, 1, 1'b0);
    apply_stimulus(1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b0, 4'b0000, 1'b0);
    check_output("final_idle", 4'b0000, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
